// File: rtl/counter_step_decoder_pkg.sv
// Shared encodings for the counter step decoder: FSM states, direction codes, default width.
package counter_pkg;
   typedef enum logic [1:0] {
      UNPRIMED = 2'd0,
      TRACK    = 2'd1,
      RESYNC   = 2'd2
   } state_e;

   localparam logic DIR_UP        = 1'b0;
   localparam logic DIR_DOWN      = 1'b1;
   localparam int   DEFAULT_WIDTH = 4;
endpackage

// File: rtl/counter_step_decoder_if.sv
// Sample/status bundle between the counter tap (master) and the step decoder (slave).
interface counter_step_decoder_if #(
   parameter int WIDTH = 4,
   parameter int POS_W = 16
);
   logic [WIDTH-1:0]        q_in;
   logic                    q_valid;
   logic                    clear_err;
   logic                    locked;
   logic                    step;
   logic                    hold;
   logic                    dir;
   logic                    dir_change;
   logic                    wrap;
   logic                    err;
   logic signed [POS_W-1:0] position;

   modport master (
      output q_in, q_valid, clear_err,
      input  locked, step, hold, dir, dir_change, wrap, err, position
   );

   modport slave (
      input  q_in, q_valid, clear_err,
      output locked, step, hold, dir, dir_change, wrap, err, position
   );
endinterface

// File: rtl/counter_step_decoder_step_classify.sv
// Combinational classification of one counter transition (prev -> q_in) modulo 2^WIDTH.
module step_classify #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] prev_i,
   input  logic [WIDTH-1:0] q_in_i,
   output logic             is_up_o,
   output logic             is_down_o,
   output logic             is_hold_o,
   output logic             is_illegal_o,
   output logic             is_wrap_o
);
   logic [WIDTH-1:0] delta;

   assign delta        = q_in_i - prev_i;
   assign is_up_o      = (delta == WIDTH'(1));
   assign is_down_o    = (delta == {WIDTH{1'b1}});
   assign is_hold_o    = (delta == '0);
   assign is_illegal_o = ~(is_up_o | is_down_o | is_hold_o);
   assign is_wrap_o    = (is_up_o & (prev_i == {WIDTH{1'b1}})) | (is_down_o & (prev_i == '0));
endmodule

// File: rtl/counter_step_decoder.sv
// Monitors successive counter samples: decodes up/down/hold/illegal steps, tracks dir,
// wraps and a saturating signed position. All outputs registered, one cycle after the sample.
module counter_step_decoder
   import counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int POS_W = 16
) (
   input logic                    Clck,
   input logic                    reset,
   counter_step_decoder_if.slave  bus
);
   localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
   localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
   localparam logic signed [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

   state_e                  state_q, state_d;
   logic [WIDTH-1:0]        prev_q, prev_d;
   logic                    dir_q, dir_d;
   logic                    have_dir_q, have_dir_d;
   logic                    err_q, err_d;
   logic                    locked_q, locked_d;
   logic                    step_q, step_d;
   logic                    hold_q, hold_d;
   logic                    dchg_q, dchg_d;
   logic                    wrap_q, wrap_d;
   logic signed [POS_W-1:0] pos_q, pos_d;

   logic is_up, is_down, is_hold, is_illegal, is_wrap;

   step_classify #(.WIDTH(WIDTH)) u_classify (
      .prev_i       (prev_q),
      .q_in_i       (bus.q_in),
      .is_up_o      (is_up),
      .is_down_o    (is_down),
      .is_hold_o    (is_hold),
      .is_illegal_o (is_illegal),
      .is_wrap_o    (is_wrap)
   );

   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      dir_d      = dir_q;
      have_dir_d = have_dir_q;
      locked_d   = locked_q;
      pos_d      = pos_q;
      step_d     = 1'b0;
      hold_d     = 1'b0;
      dchg_d     = 1'b0;
      wrap_d     = 1'b0;
      // A same-cycle illegal transition below overrides this clear.
      err_d      = err_q & ~bus.clear_err;

      if (bus.q_valid) begin
         prev_d = bus.q_in;
         unique case (state_q)
            UNPRIMED: begin
               pos_d      = '0;
               locked_d   = 1'b1;
               have_dir_d = 1'b0;
               state_d    = TRACK;
            end
            TRACK: begin
               if (is_up) begin
                  step_d     = 1'b1;
                  wrap_d     = is_wrap;
                  dir_d      = DIR_UP;
                  dchg_d     = have_dir_q & (dir_q != DIR_UP);
                  have_dir_d = 1'b1;
                  if (pos_q != POS_MAX) pos_d = pos_q + POS_ONE;
               end else if (is_down) begin
                  step_d     = 1'b1;
                  wrap_d     = is_wrap;
                  dir_d      = DIR_DOWN;
                  dchg_d     = have_dir_q & (dir_q != DIR_DOWN);
                  have_dir_d = 1'b1;
                  if (pos_q != POS_MIN) pos_d = pos_q - POS_ONE;
               end else if (is_hold) begin
                  hold_d = 1'b1;
               end else if (is_illegal) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  state_d  = RESYNC;
               end
            end
            RESYNC: begin
               locked_d   = 1'b1;
               have_dir_d = 1'b0;
               state_d    = TRACK;
            end
            default: state_d = UNPRIMED;
         endcase
      end
   end

   always_ff @(posedge Clck) begin
      if (reset) begin
         state_q    <= UNPRIMED;
         prev_q     <= '0;
         dir_q      <= DIR_UP;
         have_dir_q <= 1'b0;
         err_q      <= 1'b0;
         locked_q   <= 1'b0;
         step_q     <= 1'b0;
         hold_q     <= 1'b0;
         dchg_q     <= 1'b0;
         wrap_q     <= 1'b0;
         pos_q      <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         dir_q      <= dir_d;
         have_dir_q <= have_dir_d;
         err_q      <= err_d;
         locked_q   <= locked_d;
         step_q     <= step_d;
         hold_q     <= hold_d;
         dchg_q     <= dchg_d;
         wrap_q     <= wrap_d;
         pos_q      <= pos_d;
      end
   end

   assign bus.locked     = locked_q;
   assign bus.step       = step_q;
   assign bus.hold       = hold_q;
   assign bus.dir        = dir_q;
   assign bus.dir_change = dchg_q;
   assign bus.wrap       = wrap_q;
   assign bus.err        = err_q;
   assign bus.position   = pos_q;
endmodule

// File: tb/tb_counter_step_decoder.sv
// Directed bench for counter_step_decoder; obs = {locked, step, hold, dir, dir_change, wrap, err}.
module tb_counter_step_decoder;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   counter_step_decoder_if #(.WIDTH(4), .POS_W(16)) bus ();
   counter_step_decoder_if #(.WIDTH(4), .POS_W(4))  sbus ();

   counter_step_decoder #(.WIDTH(4), .POS_W(16)) dut (.Clck(clk), .reset(reset), .bus(bus));
   counter_step_decoder #(.WIDTH(4), .POS_W(4))  dut_sat (.Clck(clk), .reset(reset), .bus(sbus));

   always #5 clk = ~clk;

   wire [6:0] obs = {bus.locked, bus.step, bus.hold, bus.dir, bus.dir_change, bus.wrap, bus.err};

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic smp(input int v);
      bus.q_valid = 1'b1;
      bus.q_in    = 4'(v);
      @(posedge clk); #1;
      bus.q_valid = 1'b0;
   endtask

   task automatic run_seq(input string name, input int s[4], input logic [6:0] e[4], input int p[4]);
      for (int i = 0; i < 4; i++) begin
         smp(s[i]);
         n_tests++;
         if (obs !== e[i] || $signed(bus.position) !== p[i]) begin
            n_fail++;
            $display("FAIL %s[%0d] obs=%b pos=%0d expected obs=%b pos=%0d",
                     name, i, obs, $signed(bus.position), e[i], p[i]);
         end
      end
   endtask

   task automatic test_reset();
      bus.q_valid = 1'b1;
      bus.q_in    = 4'd9;
      bus.clear_err = 1'b0;
      do_reset();
      bus.q_valid = 1'b0;
      n_tests++;
      if (obs !== 7'b0 || bus.position !== 16'sd0) begin
         n_fail++;
         $display("FAIL reset obs=%b pos=%0d expected obs=0 pos=0", obs, $signed(bus.position));
      end
   endtask

   task automatic test_count();
      do_reset();
      run_seq("count", '{0, 1, 2, 3},
              '{7'b1000000, 7'b1100000, 7'b1100000, 7'b1100000}, '{0, 1, 2, 3});
   endtask

   task automatic test_up_wrap();
      do_reset();
      run_seq("up_wrap", '{14, 15, 0, 1},
              '{7'b1000000, 7'b1100000, 7'b1100010, 7'b1100000}, '{0, 1, 2, 3});
   endtask

   task automatic test_reversal();
      do_reset();
      run_seq("reversal", '{5, 6, 5, 4},
              '{7'b1000000, 7'b1100000, 7'b1101100, 7'b1101000}, '{0, 1, 0, -1});
   endtask

   task automatic test_down_wrap_hold();
      do_reset();
      run_seq("down_wrap", '{1, 0, 15, 15},
              '{7'b1000000, 7'b1101000, 7'b1101010, 7'b1011000}, '{0, -1, -2, -2});
   endtask

   task automatic test_illegal();
      do_reset();
      run_seq("illegal", '{3, 4, 9, 9},
              '{7'b1000000, 7'b1100000, 7'b0000001, 7'b1000001}, '{0, 1, 1, 1});
      smp(10);
      n_tests++;
      if (obs !== 7'b1100001 || bus.position !== 16'sd2) begin
         n_fail++;
         $display("FAIL resync_step obs=%b pos=%0d expected obs=1100001 pos=2", obs, $signed(bus.position));
      end
      @(posedge clk); #1;
      n_tests++;
      if (obs !== 7'b1000001) begin
         n_fail++;
         $display("FAIL idle_pulses obs=%b expected 1000001", obs);
      end
      bus.clear_err = 1'b1;
      @(posedge clk); #1;
      bus.clear_err = 1'b0;
      n_tests++;
      if (obs !== 7'b1000000) begin
         n_fail++;
         $display("FAIL clear_err obs=%b expected 1000000", obs);
      end
      bus.clear_err = 1'b1;
      smp(0);
      bus.clear_err = 1'b0;
      n_tests++;
      if (obs !== 7'b0000001 || bus.position !== 16'sd2) begin
         n_fail++;
         $display("FAIL set_and_clear obs=%b pos=%0d expected obs=0000001 pos=2", obs, $signed(bus.position));
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int v = 0; v <= 5; v++) smp(v);
      n_tests++;
      if (bus.position !== 16'sd5) begin
         n_fail++;
         $display("FAIL mid_pre pos=%0d expected 5", $signed(bus.position));
      end
      bus.q_valid = 1'b1;
      bus.q_in    = 4'd6;
      do_reset();
      bus.q_valid = 1'b0;
      n_tests++;
      if (obs !== 7'b0 || bus.position !== 16'sd0) begin
         n_fail++;
         $display("FAIL mid_reset obs=%b pos=%0d expected obs=0 pos=0", obs, $signed(bus.position));
      end
      smp(7);
      n_tests++;
      if (obs !== 7'b1000000 || bus.position !== 16'sd0) begin
         n_fail++;
         $display("FAIL mid_reprime obs=%b pos=%0d expected obs=1000000 pos=0", obs, $signed(bus.position));
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i <= 10; i++) begin
         sbus.q_valid = 1'b1;
         sbus.q_in    = 4'(i);
         @(posedge clk); #1;
      end
      sbus.q_valid = 1'b0;
      n_tests++;
      if (sbus.position !== 4'sd7 || sbus.step !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_pos pos=%0d step=%b expected pos=7 step=1", $signed(sbus.position), sbus.step);
      end
      for (int i = 1; i <= 20; i++) begin
         sbus.q_valid = 1'b1;
         sbus.q_in    = 4'(10 - i);
         @(posedge clk); #1;
      end
      sbus.q_valid = 1'b0;
      n_tests++;
      if (sbus.position !== -4'sd8 || sbus.dir !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_neg pos=%0d dir=%b expected pos=-8 dir=1", $signed(sbus.position), sbus.dir);
      end
   endtask

   initial begin
      reset          = 1'b0;
      bus.q_valid    = 1'b0;
      bus.q_in       = '0;
      bus.clear_err  = 1'b0;
      sbus.q_valid   = 1'b0;
      sbus.q_in      = '0;
      sbus.clear_err = 1'b0;
      #2;
      test_reset();
      test_count();
      test_up_wrap();
      test_reversal();
      test_down_wrap_hold();
      test_illegal();
      test_reset_mid();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
